// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, divide, data-bus waits, MEM exceptions.
// Optional data-bus timeout is enabled with the DMEM_TIMEOUT_EN macro.
module pipe_hazard_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DIV_CYCLES   = 32,
    parameter int unsigned DIV_CNT_W    = 6
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned TO_CNT_W     = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_load_use_i,
    input  logic        div_req_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        exc_valid_i,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        div_start_o,
    output logic        div_done_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DMEM = 2'd2
    } state_e;

    // Bit order: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb
    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] FLUSH_MEM = 5'b10000;
    localparam logic [4:0] STALL_DIV = 5'b00111;
    localparam logic [4:0] FLUSH_DIV = 5'b01000;
    localparam logic [4:0] STALL_LU  = 5'b00011;
    localparam logic [4:0] FLUSH_LU  = 5'b00100;
    localparam logic [4:0] FLUSH_EXC = 5'b11110;

    localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [DIV_CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic                   exc_pend_q, exc_pend_d;
    logic                   mem_wait;
    logic                   exc_any;
    logic                   timeout;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(DMEM_TIMEOUT - 1);

    logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;

    assign timeout = (state_q == S_DMEM) && !mem_ack_i && (to_cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    assign mem_wait = mem_req_i && !mem_ack_i;
    assign exc_any  = exc_pend_q || exc_valid_i;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            exc_pend_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            exc_pend_q <= exc_pend_d;
`ifdef DMEM_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        exc_pend_d = exc_pend_q;
`ifdef DMEM_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (exc_valid_i) begin
                    state_d = S_IDLE;
                end else if (mem_wait) begin
                    state_d = S_DMEM;
`ifdef DMEM_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (div_req_i) begin
                    state_d   = S_DIV;
                    div_cnt_d = DIV_LOAD;
                end
            end
            S_DIV: begin
                if (exc_valid_i || (div_cnt_q == '0)) begin
                    state_d = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
                end
            end
            S_DMEM: begin
                // The bus transaction runs to completion; exceptions are parked until ack
                if (mem_ack_i || timeout) begin
                    state_d    = S_IDLE;
                    exc_pend_d = 1'b0;
                end else begin
                    if (exc_valid_i) begin
                        exc_pend_d = 1'b1;
                    end
`ifdef DMEM_TIMEOUT_EN
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and current inputs
    always_comb begin
        stall_o     = '0;
        flush_o     = '0;
        div_start_o = 1'b0;
        div_done_o  = 1'b0;
        redirect_o  = 1'b0;
        bus_err_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (exc_valid_i) begin
                        flush_o    = FLUSH_EXC;
                        redirect_o = 1'b1;
                    end else if (mem_wait) begin
                        stall_o = STALL_MEM;
                        flush_o = FLUSH_MEM;
                    end else if (div_req_i) begin
                        div_start_o = 1'b1;
                        stall_o     = STALL_DIV;
                        flush_o     = FLUSH_DIV;
                    end else if (id_load_use_i) begin
                        stall_o = STALL_LU;
                        flush_o = FLUSH_LU;
                    end
                end
                S_DIV: begin
                    if (exc_valid_i) begin
                        flush_o    = FLUSH_EXC;
                        redirect_o = 1'b1;
                    end else if (div_cnt_q != '0) begin
                        stall_o = STALL_DIV;
                        flush_o = FLUSH_DIV;
                    end else begin
                        div_done_o = 1'b1;
                    end
                end
                S_DMEM: begin
                    if (mem_ack_i) begin
                        if (exc_any) begin
                            flush_o    = FLUSH_EXC;
                            redirect_o = 1'b1;
                        end
                    end else if (timeout) begin
                        bus_err_o  = 1'b1;
                        flush_o    = FLUSH_EXC;
                        redirect_o = 1'b1;
                    end else begin
                        stall_o = STALL_MEM;
                        flush_o = FLUSH_MEM;
                    end
                end
                default: begin
                    stall_o = '0;
                end
            endcase
        end
    end

    assign redirect_pc_o = redirect_o ? EXC_VECTOR : 32'h0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int          TB_DIV   = 4;
    localparam logic [31:0] TB_VEC   = 32'hBFC00380;
`ifdef DMEM_TIMEOUT_EN
    localparam bit          TB_TO_EN = 1'b1;
    localparam int          TB_TO    = 8;
`else
    localparam bit          TB_TO_EN = 1'b0;
    localparam int          TB_TO    = 0;
`endif

    logic        clk;
    logic        rst;
    logic        id_load_use_i, div_req_i, mem_req_i, mem_ack_i, exc_valid_i;
    logic [4:0]  stall_o, flush_o;
    logic        div_start_o, div_done_o, redirect_o, bus_err_o;
    logic [31:0] redirect_pc_o;

    pipe_hazard_ctrl #(
        .EXC_VECTOR (32'hBFC00380),
        .DIV_CYCLES (4),
        .DIV_CNT_W  (6)
`ifdef DMEM_TIMEOUT_EN
        ,
        .DMEM_TIMEOUT (8),
        .TO_CNT_W     (8)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_load_use_i (id_load_use_i),
        .div_req_i     (div_req_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .exc_valid_i   (exc_valid_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .div_start_o   (div_start_o),
        .div_done_o    (div_done_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .bus_err_o     (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: what the pipeline is currently waiting on, and how long it has waited
    typedef enum int {M_FREE, M_DIVIDING, M_BUS} busy_e;
    busy_e m_busy = M_FREE;
    int    m_div_stalls = 0;
    int    m_bus_waits  = 0;
    bit    m_exc_parked = 1'b0;

    // Outputs captured at the last step
    logic [4:0]  o_stall, o_flush;
    logic        o_start, o_done, o_redir, o_berr;
    logic [31:0] o_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, advance one clock
    task automatic step(input bit r, input bit lu, input bit dv, input bit mq, input bit ma, input bit ex);
        logic [4:0] e_stall, e_flush;
        bit         e_start, e_done, e_redir, e_berr;
        rst = r; id_load_use_i = lu; div_req_i = dv; mem_req_i = mq; mem_ack_i = ma; exc_valid_i = ex;
        #2;
        e_stall = 5'b0; e_flush = 5'b0;
        e_start = 1'b0; e_done = 1'b0; e_redir = 1'b0; e_berr = 1'b0;
        if (r) begin
            m_busy = M_FREE; m_div_stalls = 0; m_bus_waits = 0; m_exc_parked = 1'b0;
        end else if (m_busy == M_FREE) begin
            if (ex) begin
                e_flush = 5'b11110; e_redir = 1'b1;
            end else if (mq && !ma) begin
                e_stall = 5'b01111; e_flush = 5'b10000;
                m_busy = M_BUS; m_bus_waits = 0;
            end else if (dv) begin
                e_start = 1'b1; e_stall = 5'b00111; e_flush = 5'b01000;
                m_busy = M_DIVIDING; m_div_stalls = 1;
            end else if (lu) begin
                e_stall = 5'b00011; e_flush = 5'b00100;
            end
        end else if (m_busy == M_DIVIDING) begin
            if (ex) begin
                e_flush = 5'b11110; e_redir = 1'b1; m_busy = M_FREE;
            end else if (m_div_stalls < TB_DIV) begin
                e_stall = 5'b00111; e_flush = 5'b01000; m_div_stalls++;
            end else begin
                e_done = 1'b1; m_busy = M_FREE;
            end
        end else begin
            if (ma) begin
                if (m_exc_parked || ex) begin
                    e_flush = 5'b11110; e_redir = 1'b1;
                end
                m_busy = M_FREE; m_exc_parked = 1'b0;
            end else if (TB_TO_EN && (m_bus_waits == TB_TO - 1)) begin
                e_berr = 1'b1; e_flush = 5'b11110; e_redir = 1'b1;
                m_busy = M_FREE; m_exc_parked = 1'b0;
            end else begin
                e_stall = 5'b01111; e_flush = 5'b10000;
                m_bus_waits++;
                if (ex) m_exc_parked = 1'b1;
            end
        end
        chk("stall",    32'(stall_o),     32'(e_stall));
        chk("flush",    32'(flush_o),     32'(e_flush));
        chk("div_start", 32'(div_start_o), 32'(e_start));
        chk("div_done", 32'(div_done_o),  32'(e_done));
        chk("redirect", 32'(redirect_o),  32'(e_redir));
        chk("redir_pc", redirect_pc_o,    e_redir ? TB_VEC : 32'h0);
        chk("bus_err",  32'(bus_err_o),   32'(e_berr));
        chk("no_overlap", 32'(stall_o & flush_o), 32'h0);
        o_stall = stall_o; o_flush = flush_o; o_start = div_start_o; o_done = div_done_o;
        o_redir = redirect_o; o_berr = bus_err_o; o_pc = redirect_pc_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_load_use_i = 1'b0; div_req_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0; exc_valid_i = 1'b0;

        // Reset, then the first free cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("post_reset_stall", 32'(o_stall), 32'h0);
        chk("post_reset_redir", 32'(o_redir), 32'h0);

        // Load-use bubble for one cycle only
        step(0, 1, 0, 0, 0, 0);
        chk("lu_stall", 32'(o_stall), 32'h03);
        chk("lu_flush", 32'(o_flush), 32'h04);
        step(0, 0, 0, 0, 0, 0);
        chk("lu_release", 32'(o_stall), 32'h0);

        // Divide held until done
        step(0, 0, 1, 0, 0, 0);
        chk("div_start_pulse", 32'(o_start), 32'h1);
        chk("div_entry_stall", 32'(o_stall), 32'h07);
        for (int i = 0; i < TB_DIV - 1; i++) begin
            step(0, 0, 1, 0, 0, 0);
            chk("div_hold_stall", 32'(o_stall), 32'h07);
            chk("div_no_restart", 32'(o_start), 32'h0);
        end
        step(0, 0, 1, 0, 0, 0);
        chk("div_done", 32'(o_done), 32'h1);
        chk("div_done_stall", 32'(o_stall), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        // Bus wait with an exception raised mid-wait, taken at ack
        step(0, 0, 0, 1, 0, 0);
        chk("mem_wait0", 32'(o_stall), 32'h0F);
        step(0, 0, 0, 1, 0, 1);
        chk("mem_wait1_exc_held", 32'(o_redir), 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("mem_wait2", 32'(o_stall), 32'h0F);
        step(0, 0, 0, 1, 1, 0);
        chk("mem_ack_flush", 32'(o_flush), 32'h1E);
        chk("mem_ack_redir", 32'(o_redir), 32'h1);
        chk("mem_ack_pc", o_pc, 32'hBFC00380);
        step(0, 0, 0, 0, 0, 0);
        chk("exc_pend_cleared", 32'(o_redir), 32'h0);

        // Divide, bus wait and load-use together: bus first, divide right after
        step(0, 1, 1, 1, 0, 0);
        chk("combo_mem_first", 32'(o_stall), 32'h0F);
        chk("combo_no_start", 32'(o_start), 32'h0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 0);
        chk("combo_ack_release", 32'(o_stall), 32'h0);
        step(0, 1, 1, 0, 0, 0);
        chk("combo_div_start", 32'(o_start), 32'h1);
        for (int i = 0; i < TB_DIV; i++) step(0, 0, 1, 0, 0, 0);
        chk("combo_div_done", 32'(o_done), 32'h1);
        step(0, 0, 0, 0, 0, 0);

        // Exception aborts a divide
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        chk("div_abort_redir", 32'(o_redir), 32'h1);
        chk("div_abort_no_done", 32'(o_done), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        // Bus that never acks
`ifdef DMEM_TIMEOUT_EN
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TB_TO - 1; i++) step(0, 0, 0, 1, 0, 0);
        chk("to_not_yet", 32'(o_berr), 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("to_bus_err", 32'(o_berr), 32'h1);
        chk("to_redir", 32'(o_redir), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        chk("to_back_idle", 32'(o_stall), 32'h0);
`else
        for (int i = 0; i < 21; i++) step(0, 0, 0, 1, 0, 0);
        chk("no_to_stall", 32'(o_stall), 32'h0F);
        chk("no_to_bus_err", 32'(o_berr), 32'h0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
